// File: rtl/periph_rr_arb_node_if.sv
// Bus bundle between the per-master decoders, the arbitration node and one peripheral port.
// The slave modport is the node's view of the bundle; master is the surrounding fabric's view.
interface periph_rr_arb_node_if #(
  parameter int N_MASTER   = 16,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH   = 4,
  parameter int ID_WIDTH   = 16
);
  logic [N_MASTER-1:0]                 data_req_i;
  logic [N_MASTER-1:0][ADDR_WIDTH-1:0] data_add_i;
  logic [N_MASTER-1:0]                 data_wen_i;
  logic [N_MASTER-1:0][DATA_WIDTH-1:0] data_wdata_i;
  logic [N_MASTER-1:0][BE_WIDTH-1:0]   data_be_i;
  logic [N_MASTER-1:0][ID_WIDTH-1:0]   data_ID_i;
  logic [N_MASTER-1:0]                 data_gnt_o;
  logic [N_MASTER-1:0]                 data_r_valid_o;
  logic [DATA_WIDTH-1:0]               data_r_rdata_o;
  logic                                per_req_o;
  logic [ADDR_WIDTH-1:0]               per_add_o;
  logic                                per_wen_o;
  logic [DATA_WIDTH-1:0]               per_wdata_o;
  logic [BE_WIDTH-1:0]                 per_be_o;
  logic [ID_WIDTH-1:0]                 per_ID_o;
  logic                                per_gnt_i;
  logic                                per_r_valid_i;
  logic [DATA_WIDTH-1:0]               per_r_rdata_i;

  modport slave (
    input  data_req_i, data_add_i, data_wen_i, data_wdata_i, data_be_i, data_ID_i,
           per_gnt_i, per_r_valid_i, per_r_rdata_i,
    output data_gnt_o, data_r_valid_o, data_r_rdata_o,
           per_req_o, per_add_o, per_wen_o, per_wdata_o, per_be_o, per_ID_o
  );

  modport master (
    output data_req_i, data_add_i, data_wen_i, data_wdata_i, data_be_i, data_ID_i,
           per_gnt_i, per_r_valid_i, per_r_rdata_i,
    input  data_gnt_o, data_r_valid_o, data_r_rdata_o,
           per_req_o, per_add_o, per_wen_o, per_wdata_o, per_be_o, per_ID_o
  );
endinterface

// File: rtl/periph_rr_arb_node.sv
// Round-robin arbitration node for one peripheral slave: picks a master, forwards its request,
// backroutes the grant and steers the one-cycle-latency response to the granted master.
module periph_rr_arb_lane #(
  parameter int IW   = 4,
  parameter int LANE = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hs,
  input  logic [IW-1:0] winner,
  input  logic          r_valid_in,
  output logic          gnt,
  output logic          r_valid
);
  logic sel, resp_q;

  assign sel     = (winner == IW'(LANE));
  assign gnt     = hs & sel;
  // resp_q is this lane's bit of the response one-hot; rst masks a response still in flight
  assign r_valid = r_valid_in & resp_q & ~rst;

  always_ff @(posedge clk) begin
    if (rst) resp_q <= 1'b0;
    else     resp_q <= hs & sel;
  end
endmodule

module periph_rr_arb_node #(
  parameter int N_MASTER   = 16,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH   = 4,
  parameter int ID_WIDTH   = 16
) (
  input logic                 clk,
  input logic                 rst,
  periph_rr_arb_node_if.slave bus
);
  localparam int IW = $clog2(N_MASTER);

  typedef enum logic {ARB = 1'b0, LOCKED = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [IW-1:0]         rr_ptr, lock_idx, winner, ptr_nxt;
  logic                  req_w, hs;
  logic [N_MASTER-1:0]   gnt_w, rv_w;
  logic [ADDR_WIDTH-1:0] add_w;
  logic [DATA_WIDTH-1:0] wdata_w;
  logic [BE_WIDTH-1:0]   be_w;
  logic [ID_WIDTH-1:0]   id_w;

  // First requester at or after ptr; the reverse scan lets the smallest offset win.
  function automatic logic [IW-1:0] rr_pick(input logic [N_MASTER-1:0] req, input logic [IW-1:0] ptr);
    rr_pick = ptr;
    for (int k = N_MASTER - 1; k >= 0; k--) begin
      int j;
      j = int'(ptr) + k;
      if (j >= N_MASTER) j = j - N_MASTER;
      if (req[j]) rr_pick = IW'(j);
    end
  endfunction

  always_comb begin
    state_d = state_q;
    winner  = rr_pick(bus.data_req_i, rr_ptr);
    req_w   = |bus.data_req_i;
    if (state_q == LOCKED) begin
      // payload pinned to the stalled master; a dropped request abandons the lock without a grant
      winner = lock_idx;
      req_w  = bus.data_req_i[lock_idx];
      if (!req_w || bus.per_gnt_i) state_d = ARB;
    end else if (req_w && !bus.per_gnt_i) begin
      state_d = LOCKED;
    end
  end

  assign hs      = req_w & bus.per_gnt_i & ~rst;
  assign ptr_nxt = (winner == IW'(N_MASTER - 1)) ? '0 : winner + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ARB;
      rr_ptr   <= '0;
      lock_idx <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ARB && state_d == LOCKED) lock_idx <= winner;
      if (hs) rr_ptr <= ptr_nxt;
    end
  end

  for (genvar i = 0; i < N_MASTER; i++) begin : g_lane
    periph_rr_arb_lane #(.IW(IW), .LANE(i)) u_lane (
      .clk        (clk),
      .rst        (rst),
      .hs         (hs),
      .winner     (winner),
      .r_valid_in (bus.per_r_valid_i),
      .gnt        (gnt_w[i]),
      .r_valid    (rv_w[i])
    );
  end

  assign add_w   = bus.data_add_i[winner];
  assign wdata_w = bus.data_wdata_i[winner];
  assign be_w    = bus.data_be_i[winner];
  assign id_w    = bus.data_ID_i[winner];

  assign bus.data_gnt_o     = gnt_w;
  assign bus.data_r_valid_o = rv_w;
  assign bus.data_r_rdata_o = bus.per_r_rdata_i;
  assign bus.per_req_o      = req_w & ~rst;
  assign bus.per_add_o      = add_w;
  assign bus.per_wen_o      = bus.data_wen_i[winner];
  assign bus.per_wdata_o    = wdata_w;
  assign bus.per_be_o       = be_w;
  assign bus.per_ID_o       = id_w;
endmodule
